sipo_deser: RTL and testbench

//  Serial-in/parallel-out deserializer with valid/ready handshake on both sides.

---
 rtl/sipo_deser_pkg.sv | 8 +
 rtl/sipo_deser_if.sv | 26 ++
 rtl/sipo_deser_dff.sv | 16 +
 rtl/sipo_deser.sv | 83 ++++++++
 tb/tb_sipo_deser.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/sipo_deser_pkg.sv
// Shared helpers for the serial-in/parallel-out deserializer slice.
package sipo_deser_pkg;

  function automatic int unsigned cnt_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial-bit input side and parallel-word output side of the deserializer.
interface sipo_deser_if
  import sipo_deser_pkg::*;
#(
  parameter int unsigned Bits = 8
);
  localparam int unsigned CW = cnt_width(Bits);

  logic            bit_i;
  logic            valid_i;
  logic            ready_o;
  logic [Bits-1:0] data_o;
  logic            valid_o;
  logic            ready_i;
  logic [CW-1:0]   count_o;

  modport master (
    output bit_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, count_o
  );

  modport slave (
    input  bit_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, count_o
  );
endinterface

// File: rtl/sipo_deser_dff.sv
// Single-bit register with synchronous active-high reset to zero.
module sipo_deser_dff (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);
  logic q_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) q_q <= 1'b0;
    else        q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/sipo_deser.sv
// Deserializer: gathers Bits serial bits into a word and holds it in an
// output register until the downstream side takes it.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int unsigned Bits     = 8,
  parameter bit          MsbFirst = 1'b1
) (
  input logic         clk_i,
  input logic         srst_i,
  input logic         flush_i,
  sipo_deser_if.slave bus
);
  localparam int unsigned   CW   = cnt_width(Bits);
  localparam logic [CW-1:0] Full = CW'(Bits);
  localparam logic [CW-1:0] Last = CW'(Bits - 1);

  logic [Bits-1:0] shreg_q, shreg_d, shifted, word;
  logic [Bits-1:0] data_d, data_q;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_d, valid_q;
  logic            ready, accept, slot_free, load;

  always_comb begin
    ready     = (count_q != Full);
    accept    = bus.valid_i && ready;
    slot_free = !valid_q || bus.ready_i;
    shifted   = MsbFirst ? {shreg_q[Bits-2:0], bus.bit_i}
                         : {bus.bit_i, shreg_q[Bits-1:1]};
    word      = (count_q == Full) ? shreg_q : shifted;
    // A completed word moves out either on its last bit (fast path) or later
    // from the stalled full state; flush suppresses both.
    load      = !flush_i && slot_free &&
                ((accept && count_q == Last) || count_q == Full);

    shreg_d = shreg_q;
    count_d = count_q;
    if (flush_i) begin
      shreg_d = '0;
      count_d = '0;
    end else if (load) begin
      shreg_d = word;
      count_d = '0;
    end else if (accept) begin
      shreg_d = shifted;
      count_d = count_q + CW'(1);
    end

    data_d  = load ? word : data_q;
    valid_d = load ? 1'b1 : (valid_q && !bus.ready_i);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  for (genvar i = 0; i < Bits; i++) begin : g_data
    sipo_deser_dff u_data (
      .clk_i  (clk_i),
      .srst_i (srst_i),
      .d_i    (data_d[i]),
      .q_o    (data_q[i])
    );
  end

  sipo_deser_dff u_valid (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .d_i    (valid_d),
    .q_o    (valid_q)
  );

  assign bus.ready_o = ready;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.count_o = count_q;
endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share one stimulus
// stream and are compared against a per-instance bit-list model.
module tb_sipo_deser;
  logic clk = 1'b0;
  logic srst, flush, b, v, r;
  int   ncomp = 0;
  int   nfail = 0;

  sipo_deser_if #(.Bits(8)) if0 ();
  sipo_deser_if #(.Bits(8)) if1 ();

  assign if0.bit_i   = b;
  assign if0.valid_i = v;
  assign if0.ready_i = r;
  assign if1.bit_i   = b;
  assign if1.valid_i = v;
  assign if1.ready_i = r;

  sipo_deser #(.Bits(8), .MsbFirst(1'b1)) u0 (
    .clk_i(clk), .srst_i(srst), .flush_i(flush), .bus(if0.slave));
  sipo_deser #(.Bits(8), .MsbFirst(1'b0)) u1 (
    .clk_i(clk), .srst_i(srst), .flush_i(flush), .bus(if1.slave));

  always #5 clk = ~clk;

  // Model: bits kept in arrival order; word value computed arithmetically.
  bit          mbit   [2][8];
  int unsigned mcnt   [2];
  logic [7:0]  mdata  [2];
  bit          mvalid [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int d, input logic bb, vv, rr, ff, ss);
    int unsigned w;
    bit consume;
    if (ss) begin
      mcnt[d] = 0; mvalid[d] = 1'b0; mdata[d] = 8'h00;
      return;
    end
    consume = mvalid[d] && rr;
    if (ff) begin
      mcnt[d] = 0;
      if (consume) mvalid[d] = 1'b0;
    end else begin
      if (vv && mcnt[d] != 8) begin
        mbit[d][mcnt[d]] = bb;
        mcnt[d]++;
      end
      if (mcnt[d] == 8 && (!mvalid[d] || rr)) begin
        w = 0;
        for (int unsigned k = 0; k < 8; k++)
          if (mbit[d][k]) w += (d == 0) ? (1 << (7 - k)) : (1 << k);
        mdata[d]  = w[7:0];
        mvalid[d] = 1'b1;
        mcnt[d]   = 0;
      end else if (consume) begin
        mvalid[d] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      logic [7:0] dat;
      logic [3:0] cnt;
      logic       vo, ro;
      dat = (d == 0) ? if0.data_o  : if1.data_o;
      cnt = (d == 0) ? if0.count_o : if1.count_o;
      vo  = (d == 0) ? if0.valid_o : if1.valid_o;
      ro  = (d == 0) ? if0.ready_o : if1.ready_o;
      chk($sformatf("%s u%0d valid_o", tag, d), 32'(vo),  32'(mvalid[d]));
      chk($sformatf("%s u%0d data_o",  tag, d), 32'(dat), 32'(mdata[d]));
      chk($sformatf("%s u%0d count_o", tag, d), 32'(cnt), mcnt[d]);
      chk($sformatf("%s u%0d ready_o", tag, d), 32'(ro),  32'(mcnt[d] != 8));
    end
  endtask

  task automatic step(input logic bb, vv, rr, ff, ss, input string tag);
    b = bb; v = vv; r = rr; flush = ff; srst = ss;
    @(posedge clk);
    model_edge(0, bb, vv, rr, ff, ss);
    model_edge(1, bb, vv, rr, ff, ss);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [7:0]  pat, held, w;
    int unsigned pulses, lows;
    b = 1'b0; v = 1'b0; r = 1'b0; flush = 1'b0; srst = 1'b1;

    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "rst");
    chk("rst data", 32'(if0.data_o), 32'h0);
    chk("rst ready", 32'(if0.ready_o), 32'h1);

    // 1: A5 MSB-first, consumed immediately
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) step(pat[i], 1'b1, 1'b1, 1'b0, 1'b0, "t1");
    chk("t1 word", 32'(if0.data_o), 32'hA5);
    chk("t1 valid", 32'(if0.valid_o), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t1 idle");
    chk("t1 pulse1", 32'(if0.valid_o), 32'h0);

    // 2: stream 1,1,0,... on the LSB-first instance
    pat = 8'hC0;
    for (int i = 7; i >= 0; i--) step(pat[i], 1'b1, 1'b1, 1'b0, 1'b0, "t2");
    chk("t2 lsbfirst", 32'(if1.data_o), 32'h03);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t2 idle");

    // 3: backpressure with a second word stalled behind the first
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) step(pat[i], 1'b1, 1'b0, 1'b0, 1'b0, "t3a");
    pat = 8'h3C;
    for (int i = 7; i >= 0; i--) step(pat[i], 1'b1, 1'b0, 1'b0, 1'b0, "t3b");
    chk("t3 held", 32'(if0.data_o), 32'hA5);
    chk("t3 count", 32'(if0.count_o), 32'd8);
    chk("t3 ready", 32'(if0.ready_o), 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "t3 release");
    chk("t3 next", 32'(if0.data_o), 32'h3C);
    chk("t3 nextv", 32'(if0.valid_o), 32'h1);
    chk("t3 ready2", 32'(if0.ready_o), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t3 drain");

    // 4: 32 continuous random bits
    pulses = 0; lows = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, "t4");
      if (if0.valid_o) pulses++;
      if (!if0.ready_o) lows++;
    end
    chk("t4 pulses", pulses, 32'd4);
    chk("t4 ready lows", lows, 32'd0);

    // 5: flush with a coincident bit while a word is held
    held = if0.data_o;
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "t5 part");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t5 flush");
    chk("t5 count", 32'(if0.count_o), 32'd0);
    chk("t5 held", 32'(if0.data_o), 32'(held));
    chk("t5 heldv", 32'(if0.valid_o), 32'h1);
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      logic bt;
      bt = 1'($urandom);
      w  = 8'((w * 2) + bt);
      step(bt, 1'b1, 1'b1, 1'b0, 1'b0, "t5 word");
    end
    chk("t5 clean", 32'(if0.data_o), 32'(w));

    // 6: reset while stalled
    for (int i = 0; i < 8; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "t6 fill");
    chk("t6 stall", 32'(if0.count_o), 32'd8);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "t6 srst");
    chk("t6 valid", 32'(if0.valid_o), 32'h0);
    chk("t6 data", 32'(if0.data_o), 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(2) != 0),
           ($urandom_range(40) == 0), ($urandom_range(150) == 0), "rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
